// File: rtl/audio_xfade_router.sv
// Stereo source router: linear crossfade on source change or mute, then integer gain with saturation.
// Pipeline: stage 1 applies the fade weight, stage 2 applies gain and clips.
module audio_xfade_router #(
  parameter int SAMPLE_W   = 16,
  parameter int NUM_SRC    = 4,
  parameter int GAIN_W     = 4,
  parameter int FADE_SHIFT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid,
  input  logic [NUM_SRC*2*SAMPLE_W-1:0] src_data,
  input  logic [$clog2(NUM_SRC)-1:0]    sel,
  input  logic [GAIN_W-1:0]             gain,
  input  logic                          mute,
  output logic [2*SAMPLE_W-1:0]         out_data,
  output logic                          out_valid,
  output logic                          sat_pulse,
  output logic                          busy,
  output logic [$clog2(NUM_SRC)-1:0]    active_sel
);
  localparam int SEL_W  = $clog2(NUM_SRC);
  localparam int W_W    = FADE_SHIFT + 1;
  localparam int PROD_W = SAMPLE_W + W_W + 1;
  localparam int GP_W   = SAMPLE_W + GAIN_W + 1;
  localparam logic [W_W-1:0] W_FULL = W_W'(1 << FADE_SHIFT);
  localparam logic [W_W-1:0] W_LAST = W_W'((1 << FADE_SHIFT) - 1);
  localparam logic [W_W-1:0] W_ONE  = W_W'(1);
  localparam logic signed [GP_W-1:0] SAT_MAX = {{(GAIN_W+2){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [GP_W-1:0] SAT_MIN = {{(GAIN_W+2){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {STEADY, FADE_OUT, FADE_IN, MUTED} state_t;

  state_t           state_q, state_d;
  logic [W_W-1:0]   w_q, w_d;
  logic [SEL_W-1:0] active_q, active_d, pending_q, pending_d;
  logic             sel_ok;

  assign sel_ok = (int'(sel) < NUM_SRC);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= STEADY;
      w_q       <= W_FULL;
      active_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (sample_valid) begin
      unique case (state_q)
        STEADY: begin
          if (mute) begin
            state_d   = FADE_OUT;
            pending_d = active_q;
            w_d       = w_q - W_ONE;
          end else if (sel_ok && sel != active_q) begin
            state_d   = FADE_OUT;
            pending_d = sel;
            w_d       = w_q - W_ONE;
          end
        end
        FADE_OUT: begin
          if (w_q != '0) begin
            if (!mute && sel == active_q) begin
              w_d     = w_q + W_ONE;
              state_d = (w_q == W_LAST) ? STEADY : FADE_IN;
            end else begin
              if (!mute && sel_ok) pending_d = sel;
              w_d = w_q - W_ONE;
            end
          end else if (mute) begin
            state_d = MUTED;
          end else begin
            active_d = pending_q;
            state_d  = FADE_IN;
            w_d      = W_ONE;
          end
        end
        FADE_IN: begin
          if (mute || (sel_ok && sel != active_q)) begin
            state_d   = FADE_OUT;
            pending_d = mute ? active_q : sel;
            w_d       = w_q - W_ONE;
          end else begin
            w_d = w_q + W_ONE;
            if (w_q == W_LAST) state_d = STEADY;
          end
        end
        MUTED: begin
          w_d = '0;
          if (!mute) begin
            if (sel_ok) active_d = sel;
            state_d = FADE_IN;
            w_d     = W_ONE;
          end
        end
        default: state_d = STEADY;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != STEADY);
    active_sel = active_q;
  end

  // Stage 1: weight the routed frame with the pre-update w; |result| never exceeds |src|.
  logic [2*SAMPLE_W-1:0]      frame;
  logic signed [SAMPLE_W-1:0] src_l, src_r, scl_l, scl_r;
  logic signed [PROD_W-1:0]   w_s, prod_l, prod_r;

  always_comb begin
    frame  = src_data[active_q*(2*SAMPLE_W) +: 2*SAMPLE_W];
    src_l  = frame[2*SAMPLE_W-1 -: SAMPLE_W];
    src_r  = frame[SAMPLE_W-1:0];
    w_s    = PROD_W'(w_q);
    prod_l = PROD_W'(src_l) * w_s;
    prod_r = PROD_W'(src_r) * w_s;
    scl_l  = SAMPLE_W'(prod_l >>> FADE_SHIFT);
    scl_r  = SAMPLE_W'(prod_r >>> FADE_SHIFT);
  end

  logic                       s1_valid;
  logic signed [SAMPLE_W-1:0] s1_l, s1_r;
  logic [GAIN_W-1:0]          s1_gain;

  // NOTE: only the valid bit is reset; data registers are qualified by it and need no reset.
  always_ff @(posedge clk) begin
    if (!rst) s1_valid <= 1'b0;
    else      s1_valid <= sample_valid;
    if (sample_valid) begin
      s1_l    <= scl_l;
      s1_r    <= scl_r;
      s1_gain <= gain;
    end
  end

  function automatic logic [SAMPLE_W:0] saturate(input logic signed [GP_W-1:0] v);
    if (v > SAT_MAX)      return {1'b1, SAT_MAX[SAMPLE_W-1:0]};
    else if (v < SAT_MIN) return {1'b1, SAT_MIN[SAMPLE_W-1:0]};
    else                  return {1'b0, v[SAMPLE_W-1:0]};
  endfunction

  logic signed [GP_W-1:0] gain_s, g_l, g_r;
  logic [SAMPLE_W-1:0]    sat_l, sat_r;
  logic                   clip_l, clip_r;

  always_comb begin
    gain_s          = GP_W'(s1_gain);
    g_l             = GP_W'(s1_l) * gain_s;
    g_r             = GP_W'(s1_r) * gain_s;
    {clip_l, sat_l} = saturate(g_l);
    {clip_r, sat_r} = saturate(g_r);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      sat_pulse <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s1_valid;
      sat_pulse <= s1_valid & (clip_l | clip_r);
      if (s1_valid) out_data <= {sat_l, sat_r};
    end
  end

endmodule

// File: tb/tb_audio_xfade_router.sv
// Scoreboard bench for audio_xfade_router: directed strobes push expected frames, a monitor pops on out_valid.
// A second instance with three sources exercises out-of-range select handling.
module tb_audio_xfade_router;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sample_valid = 1'b0;
  logic [127:0] src_data = '0;
  logic [1:0]   sel = '0;
  logic [1:0]   sel3 = '0;
  logic [3:0]   gain = 4'd1;
  logic         mute = 1'b0;
  logic [31:0]  out_data;
  logic         out_valid, sat_pulse, busy;
  logic [1:0]   active_sel;
  logic [31:0]  u3_out_data;
  logic         u3_out_valid, u3_sat_pulse, u3_busy;
  logic [1:0]   u3_active_sel;

  audio_xfade_router #(.SAMPLE_W(16), .NUM_SRC(4), .GAIN_W(4), .FADE_SHIFT(2)) u_dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .src_data(src_data),
    .sel(sel), .gain(gain), .mute(mute), .out_data(out_data), .out_valid(out_valid),
    .sat_pulse(sat_pulse), .busy(busy), .active_sel(active_sel)
  );

  audio_xfade_router #(.SAMPLE_W(16), .NUM_SRC(3), .GAIN_W(4), .FADE_SHIFT(2)) u_dut3 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .src_data(src_data[95:0]),
    .sel(sel3), .gain(gain), .mute(mute), .out_data(u3_out_data), .out_valid(u3_out_valid),
    .sat_pulse(u3_sat_pulse), .busy(u3_busy), .active_sel(u3_active_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   sel3_force = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_data", out_data, e.data);
        check("sat_pulse", sat_pulse, e.sat);
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic set_src(input int idx, input int l, input int r);
    src_data[idx*32 +: 32] = {16'(l), 16'(r)};
  endtask

  // exp_busy < 0 skips the busy check for that strobe.
  task automatic strobe(input logic [1:0] s, input logic m, input logic [3:0] g,
                        input int el, input int er, input logic esat,
                        input int exp_busy, input bit push, input int gap);
    exp_t e;
    sel  = s;
    sel3 = (sel3_force >= 0) ? 2'(sel3_force) : s;
    mute = m;
    gain = g;
    if (exp_busy >= 0) check("busy_at_strobe", busy, exp_busy);
    if (push) begin
      e.data = {16'(el), 16'(er)};
      e.sat  = esat;
      e.cyc  = cyc + 2;
      q.push_back(e);
    end
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  int ex35[10]  = '{4000, 3000, 2000, 1000, 0, 2000, 4000, 6000, 8000, 8000};
  int ret0[10]  = '{8000, 6000, 4000, 2000, 0, 1000, 2000, 3000, 4000, 4000};
  int bz10[10]  = '{0, 1, 1, 1, 1, 1, 1, 1, -1, 0};
  int sel36[5]  = '{2, 0, 0, 0, 0};
  int ex36[5]   = '{4000, 3000, 4000, 4000, 4000};
  int bz36[5]   = '{0, 1, -1, -1, 0};
  int mu37[12]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  int l37[12]   = '{4000, 3000, 2000, 1000, 0, 0, 0, 1000, 2000, 3000, 4000, 4000};
  int r37[12]   = '{-1001, -751, -501, -251, 0, 0, 0, -251, -501, -751, -1001, -1001};
  int bz37[12]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, -1, 0};

  initial begin
    set_src(1, -7000, 7000);
    set_src(3, 1234, -4321);
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sat_pulse", sat_pulse, 0);
    check("reset_busy", busy, 0);
    check("reset_active_sel", active_sel, 0);
    check("reset_out_data", out_data, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Unity gain pass-through, then back-to-back strobes exercising gain and clipping.
    set_src(0, 1000, -1000);
    strobe(2'd0, 1'b0, 4'd1, 1000, -1000, 1'b0, 0, 1'b1, 3);
    set_src(0, 15000, -15000);
    strobe(2'd0, 1'b0, 4'd3, 32767, -32768, 1'b1, 0, 1'b1, 0);
    set_src(0, 11000, 5);
    strobe(2'd0, 1'b0, 4'd3, 32767, 15, 1'b1, 0, 1'b1, 0);
    set_src(0, -2185, 2184);
    strobe(2'd0, 1'b0, 4'd15, -32768, 32760, 1'b1, 0, 1'b1, 0);
    set_src(0, 1000, -1000);
    strobe(2'd0, 1'b0, 4'd0, 0, 0, 1'b0, 0, 1'b1, 0);
    set_src(0, -3, 10000);
    strobe(2'd0, 1'b0, 4'd3, -9, 30000, 1'b0, 0, 1'b1, 5);
    check("out_data_hold", out_data, {16'(-9), 16'(30000)});
    check("out_valid_idle", out_valid, 0);

    // Crossfade 0 -> 2 and back again.
    set_src(0, 4000, 4000);
    set_src(2, 8000, 8000);
    for (int i = 0; i < 10; i++)
      strobe(2'd2, 1'b0, 4'd1, ex35[i], ex35[i], 1'b0, bz10[i], 1'b1, i % 3);
    check("active_after_fade", active_sel, 2);
    for (int i = 0; i < 10; i++)
      strobe(2'd0, 1'b0, 4'd1, ret0[i], ret0[i], 1'b0, bz10[i], 1'b1, (i + 1) % 3);
    check("active_after_return", active_sel, 0);

    // Reversal mid fade-out.
    for (int i = 0; i < 5; i++) begin
      strobe(2'(sel36[i]), 1'b0, 4'd1, ex36[i], ex36[i], 1'b0, bz36[i], 1'b1, 1);
      check("active_during_reversal", active_sel, 0);
    end

    // Mute fade-out, hold, fade-in; negative right channel checks floor shifting.
    set_src(0, 4000, -1001);
    for (int i = 0; i < 12; i++)
      strobe(2'd0, 1'(mu37[i]), 4'd1, l37[i], r37[i], 1'b0, bz37[i], 1'b1, i % 2);
    check("active_after_mute", active_sel, 0);

    // Out-of-range select on the three-source instance.
    set_src(0, 4000, 4000);
    sel3_force = 3;
    strobe(2'd0, 1'b0, 4'd1, 4000, 4000, 1'b0, 0, 1'b1, 1);
    check("u3_busy_bad_sel", u3_busy, 0);
    check("u3_active_bad_sel", u3_active_sel, 0);
    sel3_force = -1;

    // Reset mid fade-out with a strobe in flight.
    strobe(2'd2, 1'b0, 4'd1, 4000, 4000, 1'b0, 0, 1'b1, 0);
    strobe(2'd2, 1'b0, 4'd1, 3000, 3000, 1'b0, 1, 1'b1, 3);
    strobe(2'd2, 1'b0, 4'd1, 0, 0, 1'b0, 1, 1'b0, 0);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("midfade_reset_busy", busy, 0);
    check("midfade_reset_active", active_sel, 0);
    check("midfade_reset_out_valid", out_valid, 0);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    strobe(2'd2, 1'b0, 4'd1, 4000, 4000, 1'b0, 0, 1'b1, 1);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    check("drain_queue", q.size(), 0);
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
